pc_sequencer: RTL and testbench

Instruction-cycle controller for the 8-bit program counter datapath (PC register with its 2:1 source mux) and the surrounding fetch path. It walks a fetch/decode/operand/execute state machine, handshakes with instruction/data memory, and drives the PC controls (SelPC, IncPC, LoadPC) plus IR, operand, accumulator and memory strobes. Instruction byte: opcode IR[7:4], short operand IR[3:0]. Long instructions carry an 8-bit address in the following byte.

---
 rtl/pc_seq_pkg.sv | 37 +++
 rtl/pc_seq_decode.sv | 38 +++
 rtl/pc_sequencer.sv | 140 ++++++++++++++
 tb/tb_pc_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared constants for the instruction-cycle sequencer: opcodes, FSM states, ALU op codes.
package pc_seq_pkg;

  localparam int unsigned OPC_W   = 4;
  localparam int unsigned IR_W    = 8;
  localparam int unsigned ALUOP_W = 2;

  localparam logic [OPC_W-1:0] OPC_NOP  = 4'h0;
  localparam logic [OPC_W-1:0] OPC_LDA  = 4'h1;
  localparam logic [OPC_W-1:0] OPC_ADD  = 4'h2;
  localparam logic [OPC_W-1:0] OPC_SUB  = 4'h3;
  localparam logic [OPC_W-1:0] OPC_STA  = 4'h4;
  localparam logic [OPC_W-1:0] OPC_JMP  = 4'h5;
  localparam logic [OPC_W-1:0] OPC_JMPS = 4'h6;
  localparam logic [OPC_W-1:0] OPC_JZ   = 4'h7;
  localparam logic [OPC_W-1:0] OPC_JC   = 4'h8;
  localparam logic [OPC_W-1:0] OPC_HLT  = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_FETCH   = 3'd2,
    ST_DECODE  = 3'd3,
    ST_OPERAND = 3'd4,
    ST_EXEC    = 3'd5,
    ST_JUMP    = 3'd6,
    ST_HALT    = 3'd7
  } state_e;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_PASS = 2'b00,
    ALU_ADD  = 2'b01,
    ALU_SUB  = 2'b10,
    ALU_RSVD = 2'b11
  } alu_op_e;

endpackage

// File: rtl/pc_seq_decode.sv
// Opcode classifier: maps IR[7:4] onto the instruction classes the sequencer branches on.
module pc_seq_decode
  import pc_seq_pkg::*;
(
  input  logic [OPC_W-1:0] opcode_i,
  output logic             is_long_o,
  output logic             is_mem_read_o,
  output logic             is_store_o,
  output logic             is_short_branch_o,
  output logic             is_halt_o,
  output logic             is_illegal_o
);

  always_comb begin
    is_long_o         = 1'b0;
    is_mem_read_o     = 1'b0;
    is_store_o        = 1'b0;
    is_short_branch_o = 1'b0;
    is_halt_o         = 1'b0;
    is_illegal_o      = 1'b0;
    unique case (opcode_i)
      OPC_NOP: ;
      OPC_LDA, OPC_ADD, OPC_SUB: begin
        is_long_o     = 1'b1;
        is_mem_read_o = 1'b1;
      end
      OPC_STA: begin
        is_long_o  = 1'b1;
        is_store_o = 1'b1;
      end
      OPC_JMP:                   is_long_o         = 1'b1;
      OPC_JMPS, OPC_JZ, OPC_JC:  is_short_branch_o = 1'b1;
      OPC_HLT:                   is_halt_o         = 1'b1;
      default:                   is_illegal_o      = 1'b1;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/decode/operand/execute controller driving the PC mux/inc/load controls,
// register strobes and the memory request handshake. Outputs are decoded from state.
module pc_sequencer
  import pc_seq_pkg::*;
(
  input  logic              CLK,
  input  logic              CLB,
  input  logic              Run,
  input  logic [IR_W-1:0]   IR,
  input  logic              ZeroFlag,
  input  logic              CarryFlag,
  input  logic              MemRdy,
  output logic              SelPC,
  output logic              IncPC,
  output logic              LoadPC,
  output logic              LoadIR,
  output logic              LoadOpr,
  output logic              LoadAcc,
  output logic              MemRd,
  output logic              MemWr,
  output logic              AddrSel,
  output logic [ALUOP_W-1:0] AluOp,
  output logic              Halted,
  output logic              IllegalOp
);

  state_e            state_q, state_d;
  logic [OPC_W-1:0]  opcode;
  logic              is_long, is_mem_read, is_store, is_short_branch, is_halt, is_illegal;
  logic              br_taken;
  alu_op_e           alu_sel;
  logic              unused_ir_operand;

  assign opcode            = IR[IR_W-1:IR_W-OPC_W];
  // Short operand feeds the PC mux directly in the datapath; not needed here.
  assign unused_ir_operand = ^IR[IR_W-OPC_W-1:0];

  pc_seq_decode u_decode (
    .opcode_i          (opcode),
    .is_long_o         (is_long),
    .is_mem_read_o     (is_mem_read),
    .is_store_o        (is_store),
    .is_short_branch_o (is_short_branch),
    .is_halt_o         (is_halt),
    .is_illegal_o      (is_illegal)
  );

  assign br_taken = is_short_branch &
                    ((opcode == OPC_JMPS) |
                     ((opcode == OPC_JZ) & ZeroFlag) |
                     ((opcode == OPC_JC) & CarryFlag));

  always_comb begin
    unique case (opcode)
      OPC_ADD: alu_sel = ALU_ADD;
      OPC_SUB: alu_sel = ALU_SUB;
      default: alu_sel = ALU_PASS;
    endcase
  end

  always_ff @(posedge CLK or negedge CLB) begin
    if (!CLB) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    SelPC     = 1'b0;
    IncPC     = 1'b0;
    LoadPC    = 1'b0;
    LoadIR    = 1'b0;
    LoadOpr   = 1'b0;
    LoadAcc   = 1'b0;
    MemRd     = 1'b0;
    MemWr     = 1'b0;
    AddrSel   = 1'b0;
    AluOp     = ALU_PASS;
    Halted    = 1'b0;
    IllegalOp = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (Run) state_d = ST_CLEAR;
      end
      // Inc+Load together is the datapath's PC-clear command.
      ST_CLEAR: begin
        IncPC   = 1'b1;
        LoadPC  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        MemRd = 1'b1;
        if (MemRdy) begin
          LoadIR  = 1'b1;
          IncPC   = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (is_long) begin
          state_d = ST_OPERAND;
        end else if (is_halt) begin
          state_d = ST_HALT;
        end else begin
          LoadPC    = br_taken;
          IllegalOp = is_illegal;
          state_d   = ST_FETCH;
        end
      end
      ST_OPERAND: begin
        MemRd = 1'b1;
        if (MemRdy) begin
          LoadOpr = 1'b1;
          IncPC   = 1'b1;
          state_d = (opcode == OPC_JMP) ? ST_JUMP : ST_EXEC;
        end
      end
      ST_EXEC: begin
        AddrSel = 1'b1;
        MemRd   = is_mem_read;
        MemWr   = is_store;
        if (MemRdy) begin
          LoadAcc = is_mem_read;
          if (is_mem_read) AluOp = alu_sel;
          state_d = ST_FETCH;
        end
      end
      ST_JUMP: begin
        LoadPC  = 1'b1;
        SelPC   = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        Halted = 1'b1;
        if (Run) state_d = ST_CLEAR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench: instruction-level model builds the expected per-cycle control vector.
module tb_pc_sequencer;

  logic       CLK = 1'b0;
  logic       CLB, Run, ZeroFlag, CarryFlag, MemRdy;
  logic [7:0] IR;
  logic       SelPC, IncPC, LoadPC, LoadIR, LoadOpr, LoadAcc, MemRd, MemWr, AddrSel;
  logic [1:0] AluOp;
  logic       Halted, IllegalOp;

  pc_sequencer dut (
    .CLK(CLK), .CLB(CLB), .Run(Run), .IR(IR), .ZeroFlag(ZeroFlag), .CarryFlag(CarryFlag),
    .MemRdy(MemRdy), .SelPC(SelPC), .IncPC(IncPC), .LoadPC(LoadPC), .LoadIR(LoadIR),
    .LoadOpr(LoadOpr), .LoadAcc(LoadAcc), .MemRd(MemRd), .MemWr(MemWr), .AddrSel(AddrSel),
    .AluOp(AluOp), .Halted(Halted), .IllegalOp(IllegalOp)
  );

  always #5 CLK = ~CLK;

  // Control vector bit positions: {SelPC,IncPC,LoadPC,LoadIR,LoadOpr,LoadAcc,MemRd,MemWr,AddrSel,AluOp,Halted,IllegalOp}
  localparam logic [12:0] SEL  = 13'h1000;
  localparam logic [12:0] INC  = 13'h0800;
  localparam logic [12:0] LPC  = 13'h0400;
  localparam logic [12:0] LIR  = 13'h0200;
  localparam logic [12:0] LOPR = 13'h0100;
  localparam logic [12:0] LACC = 13'h0080;
  localparam logic [12:0] MRD  = 13'h0040;
  localparam logic [12:0] MWR  = 13'h0020;
  localparam logic [12:0] ASEL = 13'h0010;
  localparam logic [12:0] ALU1 = 13'h0008;
  localparam logic [12:0] ALU0 = 13'h0004;
  localparam logic [12:0] HLTD = 13'h0002;
  localparam logic [12:0] ILL  = 13'h0001;

  logic [12:0] dut_vec;
  assign dut_vec = {SelPC, IncPC, LoadPC, LoadIR, LoadOpr, LoadAcc, MemRd, MemWr, AddrSel,
                    AluOp, Halted, IllegalOp};

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc_count = 0;
  string       tag = "reset";
  logic [12:0] last_vec, first_vec, dec_vec, opr_vec;

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, req);
    end
  endtask

  // One clock: drive inputs just after the edge, compare on the falling edge.
  task automatic cyc(input logic run, input logic rdy, input logic [12:0] e);
    Run    = run;
    MemRdy = rdy;
    @(negedge CLK);
    last_vec = dut_vec;
    check(tag, dut_vec, e);
    cyc_count++;
    @(posedge CLK);
    #1;
  endtask

  // Memory access with `waits` not-ready cycles; request held throughout, strobes on completion.
  task automatic access(input logic [12:0] req, input logic [12:0] fin, input int waits);
    for (int i = 0; i < waits; i++) cyc(rb(), 1'b0, req);
    cyc(rb(), 1'b1, req | fin);
  endtask

  task automatic do_instr(input logic [7:0] ir, input logic z, input logic c,
                          input int w0, input int w1, input int w2, input bit abort,
                          output int ncyc);
    logic [3:0]  op;
    logic [12:0] d;
    int          start;
    op = ir[7:4];
    IR = ir; ZeroFlag = z; CarryFlag = c;
    start = cyc_count;
    tag = $sformatf("ir%02h_fetch", ir);
    access(MRD, LIR | INC, w0);
    first_vec = (w0 > 0) ? MRD : (MRD | LIR | INC);
    d = '0;
    case (op)
      4'h6: d = LPC;
      4'h7: d = z ? LPC : '0;
      4'h8: d = c ? LPC : '0;
      4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE: d = ILL;
      default: d = '0;
    endcase
    tag = $sformatf("ir%02h_decode", ir);
    cyc(rb(), rb(), d);
    dec_vec = last_vec;
    if (op >= 4'h1 && op <= 4'h5) begin
      tag = $sformatf("ir%02h_operand", ir);
      access(MRD, LOPR | INC, w1);
      opr_vec = last_vec;
      tag = $sformatf("ir%02h_exec", ir);
      if (op == 4'h5) cyc(rb(), rb(), LPC | SEL);
      else if (op == 4'h4) begin
        if (abort) cyc(rb(), 1'b0, MWR | ASEL);
        else access(MWR | ASEL, '0, w2);
      end else
        access(MRD | ASEL, LACC | ((op == 4'h2) ? ALU0 : (op == 4'h3) ? ALU1 : '0), w2);
    end
    ncyc = cyc_count - start;
  endtask

  task automatic halt_then_run(input int k);
    tag = "halt";
    for (int i = 0; i < k; i++) cyc(1'b0, rb(), HLTD);
    cyc(1'b1, rb(), HLTD);
    tag = "clear";
    cyc(rb(), rb(), INC | LPC);
  endtask

  initial begin
    int          n;
    logic [7:0]  ir;
    CLB = 1'b0; Run = 1'b0; IR = 8'h00; ZeroFlag = 1'b0; CarryFlag = 1'b0; MemRdy = 1'b1;
    #2;
    check("reset_outputs", dut_vec, '0);
    Run = 1'b1;
    #1;
    check("reset_run_ignored", dut_vec, '0);
    Run = 1'b0;
    @(posedge CLK); #1;
    CLB = 1'b1;

    tag = "idle";
    cyc(1'b0, rb(), '0);
    cyc(1'b1, rb(), '0);
    tag = "clear";
    cyc(1'b0, rb(), INC | LPC);
    check("clear_vec", last_vec, 13'h0C00);

    do_instr(8'h63, 1'b0, 1'b0, 1, 0, 0, 1'b0, n);
    check("fetch_after_clear", first_vec, 13'h0040);
    check("jmps_decode", dec_vec, 13'h0400);
    check("jmps_cycles", 13'(n), 13'd3);

    do_instr(8'h75, 1'b0, 1'b1, 0, 0, 0, 1'b0, n);
    check("jz_untaken", dec_vec, 13'h0000);
    check("jz_untaken_cycles", 13'(n), 13'd2);
    do_instr(8'h75, 1'b1, 1'b0, 0, 0, 0, 1'b0, n);
    check("jz_taken", dec_vec, 13'h0400);

    do_instr(8'h20, 1'b0, 1'b0, 3, 3, 3, 1'b0, n);
    check("add_final", last_vec, 13'h00D4);
    check("add_wait_cycles", 13'(n), 13'd13);

    do_instr(8'h50, 1'b0, 1'b0, 0, 0, 0, 1'b0, n);
    check("jmp_operand", opr_vec, 13'h0940);
    check("jmp_jump", last_vec, 13'h1400);
    check("jmp_cycles", 13'(n), 13'd4);

    do_instr(8'h3C, 1'b0, 1'b0, 0, 0, 0, 1'b0, n);
    check("sub_final", last_vec, 13'h00D8);
    check("sub_cycles", 13'(n), 13'd4);

    do_instr(8'hA7, 1'b0, 1'b0, 0, 0, 0, 1'b0, n);
    check("illegal_pulse", dec_vec, 13'h0001);

    do_instr(8'hF0, 1'b0, 1'b0, 0, 0, 0, 1'b0, n);
    tag = "halt";
    for (int i = 0; i < 10; i++) cyc(1'b0, rb(), HLTD);
    check("halt_held", last_vec, 13'h0002);
    cyc(1'b1, 1'b0, HLTD);
    tag = "clear";
    cyc(1'b0, rb(), INC | LPC);
    check("halt_to_clear", last_vec, 13'h0C00);

    // Asynchronous reset during a held STA write.
    do_instr(8'h4A, 1'b0, 1'b0, 0, 0, 0, 1'b1, n);
    Run = 1'b0; MemRdy = 1'b0;
    #2;
    check("sta_memwr", dut_vec, 13'h0030);
    CLB = 1'b0;
    #1;
    check("rst_drops_memwr", dut_vec, 13'h0000);
    @(posedge CLK); #1;
    tag = "in_reset";
    cyc(1'b1, rb(), '0);
    CLB = 1'b1;
    tag = "idle";
    cyc(1'b0, rb(), '0);
    cyc(1'b1, rb(), '0);
    tag = "clear";
    cyc(1'b0, rb(), INC | LPC);

    for (int t = 0; t < 300; t++) begin
      ir = 8'($urandom);
      do_instr(ir, rb(), rb(), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), 1'b0, n);
      if (ir[7:4] == 4'hF) halt_then_run($urandom_range(0, 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
